// File: rtl/exc_commit_seq_pkg.sv
// Shared definitions for the exception commit sequencer.
// Holds the CSR numbers the sequencer writes or reads, the exception codes,
// the ESTAT field positions and the sequencer state encoding.
package exc_commit_seq_pkg;

    localparam logic [13:0] CSR_CRMD   = 14'h000;
    localparam logic [13:0] CSR_PRMD   = 14'h001;
    localparam logic [13:0] CSR_ESTAT  = 14'h005;
    localparam logic [13:0] CSR_ERA    = 14'h006;
    localparam logic [13:0] CSR_BADV   = 14'h007;
    localparam logic [13:0] CSR_EENTRY = 14'h00C;

    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_ADEF = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_SYS  = 6'h0B;
    localparam logic [5:0] ECODE_BRK  = 6'h0C;
    localparam logic [5:0] ECODE_INE  = 6'h0D;

    localparam int          ESTAT_ECODE_LSB = 16;
    localparam int          ESTAT_ESUB_LSB  = 22;
    localparam logic [31:0] ESTAT_EXC_WMASK = 32'h7FFF_0000;

    // CRMD/PRMD low field: PLV[1:0] and IE / PPLV[1:0] and PIE
    localparam logic [31:0] MODE_WMASK = 32'h0000_0007;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_W_PRMD  = 3'd1,
        S_W_CRMD  = 3'd2,
        S_W_ERA   = 3'd3,
        S_W_ESTAT = 3'd4,
        S_W_BADV  = 3'd5,
        S_E_CRMD  = 3'd6,
        S_REDIR   = 3'd7
    } exc_state_e;

endpackage

// File: rtl/exc_commit_seq_wr_mux.sv
// exc_csr_wr_mux: selects what drives the single CSR-file write port.
// In IDLE the pipeline csrwr/csrxchg request passes through; in the write
// states the sequencer's fixed update for that state is driven instead.
// Ports:
//   state_i                  current sequencer state
//   pipe_we_i/num/wdata/wmask pipeline request (already gated by the top)
//   crmd_i/prmd_i            latched 3-bit mode fields
//   pc_i/badv_i              latched ERA and BADV values
//   ecode_i/esub_i           latched exception code/subcode
//   csr_we_o/num/wdata/wmask CSR-file write port
module exc_csr_wr_mux
    import exc_commit_seq_pkg::*;
#(
    parameter int NUM_W = 14,
    parameter int DW    = 32
) (
    input  exc_state_e       state_i,
    input  logic             pipe_we_i,
    input  logic [NUM_W-1:0] pipe_num_i,
    input  logic [DW-1:0]    pipe_wdata_i,
    input  logic [DW-1:0]    pipe_wmask_i,
    input  logic [2:0]       crmd_i,
    input  logic [2:0]       prmd_i,
    input  logic [DW-1:0]    pc_i,
    input  logic [DW-1:0]    badv_i,
    input  logic [5:0]       ecode_i,
    input  logic [8:0]       esub_i,
    output logic             csr_we_o,
    output logic [NUM_W-1:0] csr_num_o,
    output logic [DW-1:0]    csr_wdata_o,
    output logic [DW-1:0]    csr_wmask_o
);

    logic [31:0] estat_w;

    always_comb begin
        estat_w = '0;
        estat_w[ESTAT_ECODE_LSB +: 6] = ecode_i;
        estat_w[ESTAT_ESUB_LSB  +: 9] = esub_i;
    end

    always_comb begin
        csr_we_o    = 1'b0;
        csr_num_o   = '0;
        csr_wdata_o = '0;
        csr_wmask_o = '0;
        case (state_i)
            S_IDLE: begin
                csr_we_o    = pipe_we_i;
                csr_num_o   = pipe_num_i;
                csr_wdata_o = pipe_wdata_i;
                csr_wmask_o = pipe_wmask_i;
            end
            S_W_PRMD: begin
                csr_we_o    = 1'b1;
                csr_num_o   = NUM_W'(CSR_PRMD);
                csr_wdata_o = DW'(crmd_i);
                csr_wmask_o = DW'(MODE_WMASK);
            end
            S_W_CRMD: begin
                csr_we_o    = 1'b1;
                csr_num_o   = NUM_W'(CSR_CRMD);
                csr_wmask_o = DW'(MODE_WMASK);
            end
            S_W_ERA: begin
                csr_we_o    = 1'b1;
                csr_num_o   = NUM_W'(CSR_ERA);
                csr_wdata_o = pc_i;
                csr_wmask_o = '1;
            end
            S_W_ESTAT: begin
                csr_we_o    = 1'b1;
                csr_num_o   = NUM_W'(CSR_ESTAT);
                csr_wdata_o = DW'(estat_w);
                csr_wmask_o = DW'(ESTAT_EXC_WMASK);
            end
            S_W_BADV: begin
                csr_we_o    = 1'b1;
                csr_num_o   = NUM_W'(CSR_BADV);
                csr_wdata_o = badv_i;
                csr_wmask_o = '1;
            end
            S_E_CRMD: begin
                csr_we_o    = 1'b1;
                csr_num_o   = NUM_W'(CSR_CRMD);
                csr_wdata_o = DW'(prmd_i);
                csr_wmask_o = DW'(MODE_WMASK);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/exc_commit_seq.sv
// exc_commit_seq: exception entry / ERTN return sequencer at the mm2 commit
// point. Owns the CSR-file write port, flushes IF..mm2 and redirects fetch.
// Optional macro EXC_PERF_CNT_EN adds the exc_cnt accepted-exception counter.
//
// state   | meaning
// IDLE    | pass pipeline CSR writes, wait for exception/ERTN
// W_PRMD  | save PLV/IE into PRMD
// W_CRMD  | clear PLV/IE in CRMD
// W_ERA   | save faulting PC into ERA
// W_ESTAT | write Ecode/EsubCode into ESTAT
// W_BADV  | write faulting address (ADEF/ALE only)
// E_CRMD  | ERTN: restore PLV/IE from PRMD
// REDIR   | hold redirect until IF accepts
//
// Ports: clk/reset (sync, active high); mm2_* exception and CSR request from
// mm2; csr_crmd/prmd/eentry/era current CSR values; csr_* write port;
// pipe_flush, mm2_stall, redirect_valid/pc/ready; exc_cnt (macro only).
module exc_commit_seq
    import exc_commit_seq_pkg::*;
#(
    parameter int NUM_W = 14,
    parameter int DW    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mm2_valid,
    input  logic             mm2_exc,
    input  logic             mm2_ertn,
    input  logic [5:0]       mm2_ecode,
    input  logic [8:0]       mm2_esubcode,
    input  logic [DW-1:0]    mm2_pc,
    input  logic             mm2_badv_vld,
    input  logic [DW-1:0]    mm2_badv,
    input  logic             mm2_csr_we,
    input  logic [NUM_W-1:0] mm2_csr_num,
    input  logic [DW-1:0]    mm2_csr_wdata,
    input  logic [DW-1:0]    mm2_csr_wmask,
    input  logic [DW-1:0]    csr_crmd,
    input  logic [DW-1:0]    csr_prmd,
    input  logic [DW-1:0]    csr_eentry,
    input  logic [DW-1:0]    csr_era,
    output logic             csr_we,
    output logic [NUM_W-1:0] csr_num,
    output logic [DW-1:0]    csr_wdata,
    output logic [DW-1:0]    csr_wmask,
    output logic             pipe_flush,
    output logic             mm2_stall,
    output logic             redirect_valid,
    output logic [DW-1:0]    redirect_pc,
    input  logic             redirect_ready
`ifdef EXC_PERF_CNT_EN
    ,
    output logic [31:0]      exc_cnt
`endif
);

    exc_state_e    state_q, state_d;
    logic          exc_acc, ertn_acc;
    logic          flush_q;
    logic          is_ertn_q;
    logic [DW-1:0] pc_q, badv_q, redir_pc_q;
    logic [5:0]    ecode_q;
    logic [8:0]    esub_q;
    logic          badv_vld_q;
    logic [2:0]    crmd_q, prmd_q;

    always_comb begin
        state_d  = state_q;
        exc_acc  = 1'b0;
        ertn_acc = 1'b0;
        case (state_q)
            S_IDLE: begin
                // exception has priority over a simultaneous ERTN
                if (mm2_valid && mm2_exc) begin
                    exc_acc = 1'b1;
                    state_d = S_W_PRMD;
                end else if (mm2_valid && mm2_ertn) begin
                    ertn_acc = 1'b1;
                    state_d  = S_E_CRMD;
                end
            end
            S_W_PRMD:  state_d = S_W_CRMD;
            S_W_CRMD:  state_d = S_W_ERA;
            S_W_ERA:   state_d = S_W_ESTAT;
            S_W_ESTAT: state_d = badv_vld_q ? S_W_BADV : S_REDIR;
            S_W_BADV:  state_d = S_REDIR;
            S_E_CRMD:  state_d = S_REDIR;
            S_REDIR:   if (redirect_ready) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            flush_q    <= 1'b0;
            is_ertn_q  <= 1'b0;
            pc_q       <= '0;
            badv_q     <= '0;
            redir_pc_q <= '0;
            ecode_q    <= '0;
            esub_q     <= '0;
            badv_vld_q <= 1'b0;
            crmd_q     <= '0;
            prmd_q     <= '0;
        end else begin
            state_q <= state_d;
            flush_q <= exc_acc | ertn_acc;
            if (exc_acc) begin
                is_ertn_q  <= 1'b0;
                pc_q       <= mm2_pc;
                ecode_q    <= mm2_ecode;
                esub_q     <= mm2_esubcode;
                badv_q     <= mm2_badv;
                badv_vld_q <= mm2_badv_vld;
                crmd_q     <= csr_crmd[2:0];
            end
            if (ertn_acc) begin
                is_ertn_q <= 1'b1;
                prmd_q    <= csr_prmd[2:0];
            end
            // target captured once on REDIR entry so it stays stable while IF stalls
            if (state_d == S_REDIR && state_q != S_REDIR)
                redir_pc_q <= is_ertn_q ? csr_era : csr_eentry;
        end
    end

    exc_csr_wr_mux #(.NUM_W(NUM_W), .DW(DW)) u_wr_mux (
        .state_i      (state_q),
        .pipe_we_i    (mm2_valid & mm2_csr_we & ~exc_acc & ~ertn_acc),
        .pipe_num_i   (mm2_csr_num),
        .pipe_wdata_i (mm2_csr_wdata),
        .pipe_wmask_i (mm2_csr_wmask),
        .crmd_i       (crmd_q),
        .prmd_i       (prmd_q),
        .pc_i         (pc_q),
        .badv_i       (badv_q),
        .ecode_i      (ecode_q),
        .esub_i       (esub_q),
        .csr_we_o     (csr_we),
        .csr_num_o    (csr_num),
        .csr_wdata_o  (csr_wdata),
        .csr_wmask_o  (csr_wmask)
    );

    assign pipe_flush     = flush_q;
    assign mm2_stall      = (state_q != S_IDLE);
    assign redirect_valid = (state_q == S_REDIR);
    assign redirect_pc    = redir_pc_q;

`ifdef EXC_PERF_CNT_EN
    logic [31:0] exc_cnt_q;
    always_ff @(posedge clk) begin
        if (reset)        exc_cnt_q <= '0;
        else if (exc_acc) exc_cnt_q <= exc_cnt_q + 32'd1;
    end
    assign exc_cnt = exc_cnt_q;
`endif

    logic unused_ok;
    assign unused_ok = ^{csr_crmd[DW-1:3], csr_prmd[DW-1:3]};

endmodule

// File: tb/tb_exc_commit_seq.sv
module tb_exc_commit_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        mm2_valid, mm2_exc, mm2_ertn;
    logic [5:0]  mm2_ecode;
    logic [8:0]  mm2_esubcode;
    logic [31:0] mm2_pc;
    logic        mm2_badv_vld;
    logic [31:0] mm2_badv;
    logic        mm2_csr_we;
    logic [13:0] mm2_csr_num;
    logic [31:0] mm2_csr_wdata, mm2_csr_wmask;
    logic [31:0] csr_crmd, csr_prmd, csr_eentry, csr_era;
    logic        csr_we;
    logic [13:0] csr_num;
    logic [31:0] csr_wdata, csr_wmask;
    logic        pipe_flush, mm2_stall, redirect_valid, redirect_ready;
    logic [31:0] redirect_pc;
`ifdef EXC_PERF_CNT_EN
    logic [31:0] exc_cnt;
`endif

    int n_chk = 0;
    int n_bad = 0;

    exc_commit_seq #(.NUM_W(14), .DW(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .mm2_valid      (mm2_valid),
        .mm2_exc        (mm2_exc),
        .mm2_ertn       (mm2_ertn),
        .mm2_ecode      (mm2_ecode),
        .mm2_esubcode   (mm2_esubcode),
        .mm2_pc         (mm2_pc),
        .mm2_badv_vld   (mm2_badv_vld),
        .mm2_badv       (mm2_badv),
        .mm2_csr_we     (mm2_csr_we),
        .mm2_csr_num    (mm2_csr_num),
        .mm2_csr_wdata  (mm2_csr_wdata),
        .mm2_csr_wmask  (mm2_csr_wmask),
        .csr_crmd       (csr_crmd),
        .csr_prmd       (csr_prmd),
        .csr_eentry     (csr_eentry),
        .csr_era        (csr_era),
        .csr_we         (csr_we),
        .csr_num        (csr_num),
        .csr_wdata      (csr_wdata),
        .csr_wmask      (csr_wmask),
        .pipe_flush     (pipe_flush),
        .mm2_stall      (mm2_stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .redirect_ready (redirect_ready)
`ifdef EXC_PERF_CNT_EN
        ,
        .exc_cnt        (exc_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // drive point: 1 time unit after the active edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // sample at the falling edge of the current cycle
    task automatic cyc(input string tag, input logic we, input logic [13:0] num,
                       input logic [31:0] wd, input logic [31:0] wm,
                       input logic fl, input logic rv, input logic st);
        @(negedge clk);
        chk({tag, ".we"}, 32'(csr_we), 32'(we));
        if (we) begin
            chk({tag, ".num"}, 32'(csr_num), 32'(num));
            chk({tag, ".wdata"}, csr_wdata, wd);
            chk({tag, ".wmask"}, csr_wmask, wm);
        end
        chk({tag, ".flush"}, 32'(pipe_flush), 32'(fl));
        chk({tag, ".rv"}, 32'(redirect_valid), 32'(rv));
        chk({tag, ".stall"}, 32'(mm2_stall), 32'(st));
    endtask

    task automatic clr_mm2();
        mm2_valid = 0; mm2_exc = 0; mm2_ertn = 0; mm2_ecode = '0; mm2_esubcode = '0;
        mm2_pc = '0; mm2_badv_vld = 0; mm2_badv = '0;
        mm2_csr_we = 0; mm2_csr_num = '0; mm2_csr_wdata = '0; mm2_csr_wmask = '0;
    endtask

    initial begin
        clr_mm2();
        reset = 1; redirect_ready = 0;
        csr_crmd = '0; csr_prmd = '0; csr_eentry = '0; csr_era = '0;

        // reset state
        tick();
        cyc("rst", 0, 0, 0, 0, 0, 0, 0);
        chk("rst.rpc", redirect_pc, 32'h0);
        tick(); reset = 0;

        // SYS exception, ERTN raised alongside (exception must win)
        tick();
        mm2_valid = 1; mm2_exc = 1; mm2_ertn = 1; mm2_ecode = 6'h0B;
        mm2_pc = 32'h1C00_0100; csr_crmd = 32'h7; csr_eentry = 32'h1C00_8000;
        csr_era = 32'hDEAD_0000;
        cyc("sys.T", 0, 0, 0, 0, 0, 0, 0);
        tick(); clr_mm2();
        cyc("sys.prmd", 1, 14'h1, 32'h7, 32'h7, 1, 0, 1);
        tick(); cyc("sys.crmd", 1, 14'h0, 32'h0, 32'h7, 0, 0, 1);
        tick(); cyc("sys.era", 1, 14'h6, 32'h1C00_0100, 32'hFFFF_FFFF, 0, 0, 1);
        tick(); cyc("sys.estat", 1, 14'h5, 32'h000B_0000, 32'h7FFF_0000, 0, 0, 1);
        tick(); redirect_ready = 1;
        cyc("sys.redir", 0, 0, 0, 0, 0, 1, 1);
        chk("sys.rpc", redirect_pc, 32'h1C00_8000);
        tick(); redirect_ready = 0;
        cyc("sys.idle", 0, 0, 0, 0, 0, 0, 0);

        // ALE with BADV, pipeline csrwr to 0x30 in cycle T and held during sequence
        tick();
        mm2_valid = 1; mm2_exc = 1; mm2_ecode = 6'h09; mm2_pc = 32'h1C00_0200;
        mm2_badv_vld = 1; mm2_badv = 32'h3; csr_crmd = 32'h3; csr_eentry = 32'h1C00_C000;
        mm2_csr_we = 1; mm2_csr_num = 14'h30; mm2_csr_wdata = 32'hAAAA_5555; mm2_csr_wmask = '1;
        cyc("ale.T", 0, 0, 0, 0, 0, 0, 0);
        tick(); mm2_exc = 0; mm2_ertn = 1;
        cyc("ale.prmd", 1, 14'h1, 32'h3, 32'h7, 1, 0, 1);
        tick(); cyc("ale.crmd", 1, 14'h0, 32'h0, 32'h7, 0, 0, 1);
        tick(); cyc("ale.era", 1, 14'h6, 32'h1C00_0200, 32'hFFFF_FFFF, 0, 0, 1);
        tick(); cyc("ale.estat", 1, 14'h5, 32'h0009_0000, 32'h7FFF_0000, 0, 0, 1);
        tick(); cyc("ale.badv", 1, 14'h7, 32'h3, 32'hFFFF_FFFF, 0, 0, 1);
        tick(); clr_mm2();
        cyc("ale.redir0", 0, 0, 0, 0, 0, 1, 1);
        chk("ale.rpc0", redirect_pc, 32'h1C00_C000);
        tick(); csr_eentry = 32'h1111_2222;
        cyc("ale.redir1", 0, 0, 0, 0, 0, 1, 1);
        chk("ale.rpc1", redirect_pc, 32'h1C00_C000);
        tick(); cyc("ale.redir2", 0, 0, 0, 0, 0, 1, 1);
        chk("ale.rpc2", redirect_pc, 32'h1C00_C000);
        tick(); redirect_ready = 1;
        cyc("ale.redir3", 0, 0, 0, 0, 0, 1, 1);
        tick(); redirect_ready = 0;
        cyc("ale.idle", 0, 0, 0, 0, 0, 0, 0);

        // ERTN
        tick();
        mm2_valid = 1; mm2_ertn = 1; csr_prmd = 32'h5; csr_era = 32'h1C00_0104;
        cyc("ertn.T", 0, 0, 0, 0, 0, 0, 0);
        tick(); clr_mm2();
        cyc("ertn.crmd", 1, 14'h0, 32'h5, 32'h7, 1, 0, 1);
        tick(); redirect_ready = 1;
        cyc("ertn.redir", 0, 0, 0, 0, 0, 1, 1);
        chk("ertn.rpc", redirect_pc, 32'h1C00_0104);
        tick(); redirect_ready = 0;
        cyc("ertn.idle", 0, 0, 0, 0, 0, 0, 0);

        // reset while in W_ERA
        tick();
        mm2_valid = 1; mm2_exc = 1; mm2_ecode = 6'h0B; mm2_pc = 32'h1C00_0300;
        csr_crmd = 32'h7; csr_eentry = 32'h1C00_8000;
        cyc("rsq.T", 0, 0, 0, 0, 0, 0, 0);
        tick(); clr_mm2();
        cyc("rsq.prmd", 1, 14'h1, 32'h7, 32'h7, 1, 0, 1);
        tick(); cyc("rsq.crmd", 1, 14'h0, 32'h0, 32'h7, 0, 0, 1);
        tick(); reset = 1; redirect_ready = 1;
        cyc("rsq.era", 1, 14'h6, 32'h1C00_0300, 32'hFFFF_FFFF, 0, 0, 1);
        tick(); reset = 0;
        cyc("rsq.after", 0, 0, 0, 0, 0, 0, 0);
        chk("rsq.rpc", redirect_pc, 32'h0);
        tick(); cyc("rsq.quiet", 0, 0, 0, 0, 0, 0, 0);
        tick(); redirect_ready = 0;
        mm2_valid = 1; mm2_csr_we = 1; mm2_csr_num = 14'h30;
        mm2_csr_wdata = 32'h1234_5678; mm2_csr_wmask = 32'h0000_FFFF;
        cyc("rsq.csrwr", 1, 14'h30, 32'h1234_5678, 32'h0000_FFFF, 0, 0, 0);
        tick(); mm2_valid = 0;
        cyc("csrwr.noval", 0, 0, 0, 0, 0, 0, 0);
        tick(); clr_mm2();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
